// File: rtl/simon_serial_host.sv
// Parallel-to-serial host bridge for the bit-serial Simon core: key load, plaintext
// load LSB-first, run, then deserialise the cipher stream into a parallel block.
module simon_serial_host #(
    parameter int BLOCK_W     = 64,
    parameter int KEY_W       = 128,
    parameter int KEY_LOAD_EN = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               busy,
    output logic               timeout,
    output logic               core_data_in,
    output logic [1:0]         core_data_rdy,
    input  logic               core_cipher_out,
    input  logic               core_valid,
    output logic [2:0]         dbg_state
);

    localparam int CNT_MAX = (KEY_W > BLOCK_W) ? KEY_W : BLOCK_W;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_W - 1);
    localparam logic [CW-1:0] BLK_LAST  = CW'(BLOCK_W - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_KEY, S_LOAD_PT, S_RUN, S_COLLECT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [BLOCK_W-1:0] sr_q, sr_d;
    logic [BLOCK_W-1:0] out_block_q, out_block_d;
    logic               timeout_q, timeout_d;
    logic [BLOCK_W-1:0] cap_shift;
    logic [TW-1:0]      tmo_inc;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and out_block is held while out_valid is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            sr_q        <= '0;
            out_block_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sr_q        <= sr_d;
            out_block_q <= out_block_d;
            timeout_q   <= timeout_d;
        end
    end

    // The plaintext shift register empties during LOAD_PT, so it is reused to collect.
    assign cap_shift = {core_cipher_out, sr_q[BLOCK_W-1:1]};
    assign tmo_inc   = tmo_q + TW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        sr_d          = sr_q;
        out_block_d   = out_block_q;
        timeout_d     = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        core_data_in  = 1'b0;
        core_data_rdy = 2'b00;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_d    = in_block;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = (KEY_LOAD_EN != 0) ? S_LOAD_KEY : S_LOAD_PT;
                end
            end
            S_LOAD_KEY: begin
                core_data_rdy = 2'b01;
                if (cnt_q == KEY_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_PT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD_PT: begin
                core_data_rdy = 2'b10;
                core_data_in  = sr_q[0];
                sr_d          = sr_q >> 1;
                if (cnt_q == BLK_LAST) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN, S_COLLECT: begin
                core_data_rdy = 2'b11;
                if (core_valid) begin
                    sr_d  = cap_shift;
                    tmo_d = '0;
                    if (state_q == S_RUN) begin
                        cnt_d   = CW'(1);
                        state_d = S_COLLECT;
                    end else if (cnt_q == BLK_LAST) begin
                        cnt_d       = '0;
                        out_block_d = cap_shift;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmo_inc == TMO_LIMIT) begin
                    // Abort: drop the partial block and never raise out_valid.
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    cnt_d     = '0;
                    sr_d      = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign timeout   = timeout_q;
    assign out_block = out_block_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_serial_host.sv
// Directed + randomized bench for simon_serial_host with a behavioural core model
// that streams a chosen ciphertext back with configurable gaps.
module tb_simon_serial_host;

    localparam int BW  = 64;
    localparam int KW  = 128;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_block;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_block;
    logic          busy;
    logic          timeout;
    logic          core_data_in;
    logic [1:0]    core_data_rdy;
    logic          core_cipher_out = 1'b0;
    logic          core_valid = 1'b0;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];

    // Core model controls
    logic [BW-1:0] cm_bits = '0;
    bit            cm_silent = 1'b0;
    int            cm_gap_a = -1;
    int            cm_gap_b = -1;
    int            cm_gap_len = 0;
    int            cm_idx = 0;
    int            cm_gap = 0;

    simon_serial_host #(
        .BLOCK_W(BW), .KEY_W(KW), .KEY_LOAD_EN(1), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy), .timeout(timeout),
        .core_data_in(core_data_in), .core_data_rdy(core_data_rdy),
        .core_cipher_out(core_cipher_out), .core_valid(core_valid),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- core model ----------------
    // While running, present cm_bits LSB-first, pausing cm_gap_len cycles after
    // bits cm_gap_a / cm_gap_b. Outside run it emits random junk on core_valid.
    always @(negedge clk) begin
        if (core_data_rdy == 2'b11 && !cm_silent) begin
            if (cm_gap > 0) begin
                core_valid      = 1'b0;
                core_cipher_out = 1'($urandom_range(0, 1));
                cm_gap          = cm_gap - 1;
            end else if (cm_idx < BW) begin
                core_valid      = 1'b1;
                core_cipher_out = cm_bits[cm_idx];
                if (cm_idx == cm_gap_a || cm_idx == cm_gap_b) cm_gap = cm_gap_len;
                cm_idx = cm_idx + 1;
            end else begin
                core_valid = 1'b0;
            end
        end else if (core_data_rdy == 2'b11) begin
            core_valid = 1'b0;
        end else begin
            core_valid      = 1'($urandom_range(0, 1));
            core_cipher_out = 1'($urandom_range(0, 1));
            cm_idx          = 0;
            cm_gap          = 0;
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Accept a block and verify key-load and plaintext-load phases, ending on the
    // first RUN cycle.
    task automatic start_block(input logic [BW-1:0] pt);
        bit            key_ok;
        bit            pt_ok;
        logic [BW-1:0] pt_obs;
        chk("idle_in_ready", BW'(in_ready), BW'(1));
        in_valid = 1'b1;
        in_block = pt;
        @(negedge clk);
        key_ok = 1'b1;
        for (int i = 0; i < KW; i++) begin
            if (!(core_data_rdy == 2'b01 && core_data_in == 1'b0 && busy && !in_ready))
                key_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_block = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("key_phase", BW'(key_ok), BW'(1));
        pt_ok  = 1'b1;
        pt_obs = '0;
        for (int i = 0; i < BW; i++) begin
            if (core_data_rdy != 2'b10 || in_ready) pt_ok = 1'b0;
            pt_obs[i] = core_data_in;
            @(negedge clk);
        end
        chk("pt_phase_rdy", BW'(pt_ok), BW'(1));
        chk("pt_bits", pt_obs, pt);
        chk("run_rdy", BW'(core_data_rdy), BW'(2'b11));
    endtask

    // Wait for the ciphertext, apply backpressure (or early ready), complete handshake.
    task automatic finish_block(input bit early, input int bp);
        int            n;
        bit            stable;
        logic [BW-1:0] expv;
        if (early) out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", BW'(out_valid), BW'(1));
        expv = exp_q.pop_front();
        chk("out_block", out_block, expv);
        if (!early) begin
            stable = 1'b1;
            for (int i = 0; i < bp; i++) begin
                in_valid = 1'b1;
                in_block = {$urandom, $urandom};
                @(negedge clk);
                if (!(out_valid && busy && !in_ready && out_block === expv)) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk("backpressure_hold", BW'(stable), BW'(1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", BW'(out_valid), BW'(0));
        chk("post_hs_in_ready", BW'(in_ready), BW'(1));
    endtask

    task automatic run_block(input logic [BW-1:0] pt, input logic [BW-1:0] ct,
                             input int ga, input int gb, input int glen,
                             input bit early, input int bp);
        cm_bits    = ct;
        cm_gap_a   = ga;
        cm_gap_b   = gb;
        cm_gap_len = glen;
        exp_q.push_back(ct);
        start_block(pt);
        finish_block(early, bp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int at_k;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;

        // reset
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_rdy", BW'(core_data_rdy), BW'(0));
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_timeout", BW'(timeout), BW'(0));
        chk("rst_out_block", out_block, BW'(0));
        chk("rst_data_in", BW'(core_data_in), BW'(0));
        @(negedge clk);

        // directed block with gaps after bits 10 and 40, 20 cycles backpressure
        run_block(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 10, 40, 3, 1'b0, 20);

        // out_ready already high when out_valid rises
        run_block({$urandom, $urandom}, {$urandom, $urandom}, -1, -1, 0, 1'b1, 0);

        // randomized blocks
        for (int r = 0; r < 4; r++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, BW - 1), $urandom_range(0, BW - 1),
                      $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 20));
        end

        // timeout: core never answers
        cm_silent = 1'b1;
        start_block({$urandom, $urandom});
        pulses = 0;
        at_k   = -1;
        for (int k = 0; k < 40; k++) begin
            if (timeout) begin
                pulses++;
                at_k = k;
                chk("to_in_ready", BW'(in_ready), BW'(1));
                chk("to_rdy", BW'(core_data_rdy), BW'(0));
                chk("to_out_valid", BW'(out_valid), BW'(0));
            end
            @(negedge clk);
        end
        chk("to_pulse_count", BW'(pulses), BW'(1));
        chk("to_pulse_cycle", BW'(at_k), BW'(TMO));
        cm_silent = 1'b0;

        // mid-operation asynchronous reset during plaintext bit 30
        in_valid = 1'b1;
        in_block = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (KW + 30) @(negedge clk);
        chk("mid_pt_rdy", BW'(core_data_rdy), BW'(2'b10));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_rdy", BW'(core_data_rdy), BW'(0));
        chk("async_rst_busy", BW'(busy), BW'(0));
        chk("async_rst_in_ready", BW'(in_ready), BW'(1));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_block({$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, BW - 1), -1, 2, 1'b0, 5);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_serial_host.md
Name: simon_serial_host

Overview:
- Host-side bridge that drives the bit-serial Simon core (simon_module) from a parallel block interface.
- Accepts a parallel plaintext block over a valid/ready handshake and issues the key-load phase (zero key bits). Then serialises the plaintext LSB-first onto the core's data_in/data_rdy and runs the core.
- Deserialises the core's cipher_out stream while valid is high, and presents the ciphertext block on a parallel valid/ready output.
- Sits between the system bus logic and simon_module, replacing ad-hoc testbench-style driving of the core.

Parameters:
- BLOCK_W, 64: plaintext/ciphertext width in bits; serial length of the plaintext-load and collect phases.
- KEY_W, 128: number of key-load cycles issued with data_rdy=2'b01.
- KEY_LOAD_EN, 1: 1 = issue the key-load phase before every block; 0 = skip it.
- TIMEOUT_CYC, 4096: maximum consecutive cycles in RUN/COLLECT without a captured cipher bit.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  host presents a plaintext block.
- in_ready  output  1  bridge can accept a block (IDLE only).
- in_block  input  BLOCK_W  plaintext; bit 0 is serialised first.
- out_valid  output  1  ciphertext block available.
- out_ready  input  1  host accepts the ciphertext.
- out_block  output  BLOCK_W  ciphertext; bit 0 is the first captured bit.
- busy  output  1  high in any state other than IDLE.
- timeout  output  1  one-cycle pulse on timeout abort.
- core_data_in  output  1  to simon_module.data_in.
- core_data_rdy  output  2  to simon_module.data_rdy:
  - 00 idle
  - 01 key load
  - 10 plaintext load
  - 11 run
- core_cipher_out  input  1  from simon_module.cipher_out.
- core_valid  input  1  from simon_module.valid; high on each cycle a cipher bit is presented.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; in_ready=1; out_valid=0; out_block=0; busy=0; timeout=0.
  - core_data_in=0; core_data_rdy=00; all counters and the timeout counter 0.
- States: IDLE, LOAD_KEY, LOAD_PT, RUN, COLLECT, DONE.
- IDLE:
  - in_ready=1, core_data_rdy=00.
  - On in_valid&&in_ready, latch in_block into the shift register and clear the bit counter.
  - Go to LOAD_KEY if KEY_LOAD_EN=1, else LOAD_PT.
- LOAD_KEY:
  - core_data_rdy=01, core_data_in=0, for exactly KEY_W cycles, then go to LOAD_PT.
- LOAD_PT:
  - core_data_rdy=10 for exactly BLOCK_W cycles.
  - core_data_in = shift register bit 0; shift right by one each cycle.
  - After the last bit, go to RUN.
- RUN:
  - core_data_rdy=11, core_data_in=0.
  - The timeout counter increments each cycle.
  - The first cycle with core_valid=1 captures core_cipher_out as bit 0 and moves to COLLECT.
- COLLECT:
  - core_data_rdy=11.
  - Each cycle with core_valid=1 captures the next bit: shift in at the MSB, shift right, so bit 0 ends at LSB.
  - Gaps (core_valid=0) are tolerated; no bit is captured during a gap.
  - The timeout counter clears on every captured bit and increments otherwise.
  - After BLOCK_W bits are captured, load out_block and go to DONE.
- DONE:
  - core_data_rdy=00; out_valid=1.
  - out_block is held stable until out_valid&&out_ready.
  - On handshake: out_valid=0 next cycle, go to IDLE.
  - out_ready may be high on the cycle out_valid rises; the handshake then completes in that cycle.
- Latency (KEY_LOAD_EN=1): first plaintext bit on core_data_in at cycle 1+KEY_W after the accept edge; RUN entered at cycle 1+KEY_W+BLOCK_W.
- Timeout:
  - If the timeout counter reaches TIMEOUT_CYC in RUN or COLLECT: pulse timeout for 1 cycle, discard partial data, go to IDLE.
  - out_valid is not asserted on a timeout abort.
- Boundary conditions:
  - in_valid while busy is ignored (in_ready=0).
  - core_valid outside RUN/COLLECT is ignored.
  - An asynchronous reset mid-operation returns everything to reset values immediately; core_data_rdy=00 ensures the core sees idle.
- Counter widths: $clog2 of max(KEY_W, BLOCK_W)+1 and $clog2(TIMEOUT_CYC+1). No wrap-around occurs within a phase.

Test Plan:
- Reset check: hold reset=0 for 5 cycles, release. Required: in_ready=1, busy=0, core_data_rdy=00, out_valid=0, timeout=0.
- Load sequence: in_block=64'h0123_4567_89AB_CDEF, KEY_LOAD_EN=1. Required:
  - 128 cycles of data_rdy=01 with data_in=0.
  - Then 64 cycles of data_rdy=10 with data_in sequence 1,1,1,1,0,1,1,1,... (LSB-first of 0x...CDEF).
  - Then data_rdy=11.
- Collect with gaps: a core model returns 64'hFEDC_BA98_7654_3210 LSB-first, with core_valid dropped for 3 cycles after bits 10 and 40. Required: out_valid=1 with out_block=64'hFEDC_BA98_7654_3210.
- Output backpressure: out_ready=0 for 20 cycles after out_valid rises. Required: out_block stable, state DONE; a new in_valid is not accepted until 1 cycle after the handshake.
- Timeout: with TIMEOUT_CYC=16, the core never asserts core_valid. Required: timeout pulses exactly once, 16 cycles after entering RUN; then in_ready=1 and data_rdy=00.
- Mid-operation reset: assert reset=0 during LOAD_PT bit 30. Required: core_data_rdy=00 and busy=0 asynchronously; a subsequent block completes correctly.
